// File: rtl/frame_seq_ctrl_if.sv
// Frame-buffer read port and outgoing valid/ready pixel stream of frame_seq_ctrl.
interface frame_seq_ctrl_if #(
  parameter int AW = 17,
  parameter int DW = 24
);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;

  modport master (
    output mem_rd, mem_addr, m_valid, m_data, m_sof, m_eol,
    input  mem_data, m_ready
  );

  modport slave (
    input  mem_rd, mem_addr, m_valid, m_data, m_sof, m_eol,
    output mem_data, m_ready
  );
endinterface

// File: rtl/frame_seq_ctrl.sv
// Raster readout sequencer: frame-buffer addressing, H/V blanking, 2-entry skid FIFO, frame count.
// Define SEQ_TPG_EN to replace memory pixels with a {row,col,frame} test pattern.
module frame_seq_ctrl #(
  parameter int NCOL   = 349,
  parameter int NROW   = 349,
  parameter int HBLANK = 4,
  parameter int VBLANK = 16,
  parameter int AW     = 17,
  parameter int DW     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  frame_seq_ctrl_if.master bus
);
  localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int RW   = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NROW - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LAST  = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic          sof;
    logic          eol;
    logic          lst;
  } ent_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] blank_cnt;
  logic [AW-1:0] addr;
  logic          rd_go;
  logic          p_vld, p_sof, p_eol, p_lst;
  ent_t          fifo0, fifo1, wr_ent;
  logic [1:0]    occ;
  logic          push, pop;

  // FIFO occupancy plus the read whose data is on mem_data now never exceeds two entries.
  assign rd_go = (state == S_ACTIVE) && ((occ + {1'b0, p_vld}) < 2'd2);
  assign push  = p_vld;
  assign pop   = bus.m_valid && bus.m_ready;

  assign busy         = (state != S_IDLE) || (occ != 2'd0) || p_vld;
  assign bus.mem_addr = addr;
  assign bus.m_valid  = (occ != 2'd0);
  assign bus.m_data   = fifo0.pix;
  assign bus.m_sof    = fifo0.sof;
  assign bus.m_eol    = fifo0.eol;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      blank_cnt <= '0;
      addr      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            state <= S_ACTIVE;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
          end
        end
        S_ACTIVE: begin
          if (rd_go) begin
            addr <= addr + 1'b1;
            if (col == COL_LAST) begin
              col       <= '0;
              blank_cnt <= '0;
              if (row != ROW_LAST) begin
                row <= row + 1'b1;
                if (HBLANK > 0) state <= S_HBLANK;
              end else if (VBLANK > 0) begin
                state <= S_VBLANK;
              end else begin
                row   <= '0;
                addr  <= '0;
                state <= continuous ? S_ACTIVE : S_IDLE;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_HBLANK: begin
          if (blank_cnt == HB_LAST) state <= S_ACTIVE;
          else                      blank_cnt <= blank_cnt + 1'b1;
        end
        S_VBLANK: begin
          if (blank_cnt == VB_LAST) begin
            row   <= '0;
            col   <= '0;
            addr  <= '0;
            state <= continuous ? S_ACTIVE : S_IDLE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sideband tags travel one cycle alongside the read so they meet mem_data at the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld      <= 1'b0;
      p_sof      <= 1'b0;
      p_eol      <= 1'b0;
      p_lst      <= 1'b0;
      occ        <= '0;
      fifo0      <= '0;
      fifo1      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      p_vld <= rd_go;
      p_sof <= (row == '0) && (col == '0);
      p_eol <= (col == COL_LAST);
      p_lst <= (col == COL_LAST) && (row == ROW_LAST);
      if (pop) begin
        if (occ == 2'd2) fifo0 <= fifo1;
        else if (push)   fifo0 <= wr_ent;
      end else if (push) begin
        if (occ == 2'd0) fifo0 <= wr_ent;
        else             fifo1 <= wr_ent;
      end
      occ        <= occ + {1'b0, push} - {1'b0, pop};
      frame_done <= pop && fifo0.lst;
      if (pop && fifo0.lst) frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef SEQ_TPG_EN
  logic [DW-1:0] p_pix;
  logic          unused_mem_data;

  assign unused_mem_data = ^bus.mem_data;
  assign bus.mem_rd      = 1'b0;
  assign wr_ent          = '{pix: p_pix, sof: p_sof, eol: p_eol, lst: p_lst};

  always_ff @(posedge clk) begin
    if (rst) p_pix <= '0;
    else     p_pix <= DW'({8'(row), 8'(col), frame_cnt[7:0]});
  end
`else
  assign bus.mem_rd = rd_go;
  assign wr_ent     = '{pix: bus.mem_data, sof: p_sof, eol: p_eol, lst: p_lst};
`endif
endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Randomized self-checking bench for frame_seq_ctrl against a frame-level pixel/address model.
module tb_frame_seq_ctrl;
  localparam int NCOL   = 4;
  localparam int NROW   = 3;
  localparam int HBLANK = 2;
  localparam int VBLANK = 3;
  localparam int AW     = 17;
  localparam int DW     = 24;
  localparam int NPIX   = NCOL * NROW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  frame_seq_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  frame_seq_ctrl #(
    .NCOL(NCOL), .NROW(NROW), .HBLANK(HBLANK), .VBLANK(VBLANK), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pix;
    bit            sof;
    bit            eol;
    bit            lst;
  } pix_t;

  pix_t          exp_q[$];
  pix_t          e_mon;
  logic [DW-1:0] mem [NPIX];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            rnd_ready = 1'b0;
  int            fc_model = 0;
  int            n_hs = 0;
  int            n_fd = 0;
  bit            fd_due = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW+1:0] held = '0;
  int            last_addr = -1;
  int            gap = 0;
  int            n_out = 0;
  int            exp_a;
  bit            hs;
  int            lat;
  int            base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous frame buffer: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd && int'(bus.mem_addr) < NPIX) bus.mem_data <= mem[int'(bus.mem_addr)];
    else                                         bus.mem_data <= DW'($urandom);
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      fd_due     = 1'b0;
      fc_model   = 0;
      stall_prev = 1'b0;
      last_addr  = -1;
      gap        = 0;
      n_out      = 0;
    end else begin
      hs = bus.m_valid && bus.m_ready;
      if (fd_due) fc_model++;
      if (frame_done) n_fd++;
      check("frame_done", frame_done, fd_due);
      check("frame_cnt", frame_cnt, 32'(fc_model % 65536));
      fd_due = 1'b0;
      if (stall_prev) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_hold", {bus.m_data, bus.m_sof, bus.m_eol}, held);
      end
`ifdef SEQ_TPG_EN
      check("tpg_mem_rd", bus.mem_rd, 0);
`else
      if (bus.mem_rd) begin
        exp_a = (last_addr < 0 || last_addr == NPIX - 1) ? 0 : last_addr + 1;
        check("rd_addr", bus.mem_addr, exp_a);
        if (last_addr == NPIX - 1)
          check("vblank_gap", gap >= VBLANK, 1);
        else if (last_addr >= 0 && last_addr % NCOL == NCOL - 1)
          check("hblank_gap", gap >= HBLANK, 1);
        check("outstanding", n_out < 2, 1);
        last_addr = int'(bus.mem_addr);
        gap = 0;
        n_out++;
      end else begin
        gap++;
      end
`endif
      if (hs) begin
        n_hs++;
        n_out--;
        check("pix_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_mon = exp_q.pop_front();
          check("pix_data", bus.m_data, e_mon.pix);
          check("pix_sof", bus.m_sof, e_mon.sof);
          check("pix_eol", bus.m_eol, e_mon.eol);
          fd_due = e_mon.lst;
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held = {bus.m_data, bus.m_sof, bus.m_eol};
    end
  end

  task automatic push_frames(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NPIX; i++) begin
        pix_t e;
`ifdef SEQ_TPG_EN
        e.pix = {8'(i / NCOL), 8'(i % NCOL), 8'(fc_model + k)};
`else
        e.pix = mem[i];
`endif
        e.sof = (i == 0);
        e.eol = (i % NCOL == NCOL - 1);
        e.lst = (i == NPIX - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_idle_bound"}, n < budget, 1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (n_hs < target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check("hs_bound", n < budget, 1);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_sof", bus.m_sof, 0);
    check("rst_m_eol", bus.m_eol, 0);
    rst = 1'b0;

    // single frame, full-rate sink, first-pixel latency
    push_frames(1);
    pulse_start();
    lat = 0;
    while (!bus.m_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check("first_valid_latency", lat, 2);
    wait_idle("s1", 300);
    check("s1_frame_cnt", frame_cnt, 1);
    check("s1_done_pulses", n_fd, 1);
    check("s1_busy", busy, 0);

    // random backpressure, fresh memory contents per frame
    rnd_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
      push_frames(1);
      pulse_start();
      wait_idle("s2", 600);
      check("s2_frame_cnt", frame_cnt, 2 + r);
    end
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // start while busy is ignored
    push_frames(1);
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    pulse_start();
    wait_idle("s5", 300);
    repeat (20) @(posedge clk);
    #1;
    check("s5_frame_cnt", frame_cnt, 5);
    check("s5_busy", busy, 0);

    // continuous mode, dropped during the third frame
    base = n_hs;
    push_frames(3);
    continuous = 1'b1;
    pulse_start();
    wait_hs(base + 2 * NPIX + 1, 600);
    continuous = 1'b0;
    wait_idle("s3", 600);
    repeat (20) @(posedge clk);
    #1;
    check("s3_frame_cnt", frame_cnt, 8);
    check("s3_busy", busy, 0);
    check("s3_pixels", n_hs - base, 3 * NPIX);

    // reset mid-frame, then a clean frame
    push_frames(1);
    pulse_start();
    wait_hs(n_hs + 5, 300);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_mem_rd", bus.mem_rd, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_data", bus.m_data, 0);
    check("mid_rst_m_sof", bus.m_sof, 0);
    check("mid_rst_m_eol", bus.m_eol, 0);
    rst = 1'b0;
    push_frames(1);
    pulse_start();
    wait_idle("s4", 300);
    check("s4_frame_cnt", frame_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required $finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule
